// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared match state and winner codes
// Used by match_ctrl; winner codes are common with the physics engine and renderer.
package match_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } match_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2
  } winner_e;

  function automatic logic is_player(input logic [1:0] w);
    return (w == WIN_P1) || (w == WIN_P2);
  endfunction

endpackage

// File: rtl/rise_det.sv
// rtl/rise_det.sv - registered rising-edge detector with sample enable
// The history bit only advances when en is high, so a level held across disabled cycles gives one rise.
module rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic rise
);

  logic q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

  assign rise = en & d & ~q;

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - match sequencing, scoring and physics frame gating
// Optional MATCH_WIN_BY_TWO_EN: require a two-point lead, with SCORE_MAX as an absolute win.
module match_ctrl
  import match_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SCORE_W      = 4,
  parameter int PAUSE_FRAMES = 90
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               phys_valid,
  input  logic               phys_game_over,
  input  logic [1:0]         phys_winner,
  output logic               phys_en,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic [1:0]         match_state,
  output logic [1:0]         match_winner,
  output logic               point_pulse
);

  localparam int PCNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [PCNT_W-1:0]  PAUSE_LOAD = PCNT_W'(PAUSE_FRAMES - 1);

  match_state_e       state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d, p1_inc, p2_inc;
  logic [1:0]         win_q, win_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               pulse_q, pulse_d;
  logic               st_rise, go_rise, p1_wins, p2_wins;

  rise_det u_start_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .d     (start_btn),
    .rise  (st_rise)
  );

  // game_over is only meaningful on physics update strobes
  rise_det u_go_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (phys_valid),
    .d     (phys_game_over),
    .rise  (go_rise)
  );

  assign p1_inc = (p1_q == SCORE_MAX) ? p1_q : p1_q + SCORE_W'(1);
  assign p2_inc = (p2_q == SCORE_MAX) ? p2_q : p2_q + SCORE_W'(1);

`ifdef MATCH_WIN_BY_TWO_EN
  assign p1_wins = (p1_inc == SCORE_MAX) ||
                   ((int'(p1_inc) >= WIN_SCORE) && (int'(p1_inc) >= int'(p2_q) + 2));
  assign p2_wins = (p2_inc == SCORE_MAX) ||
                   ((int'(p2_inc) >= WIN_SCORE) && (int'(p2_inc) >= int'(p1_q) + 2));
`else
  assign p1_wins = int'(p1_inc) >= WIN_SCORE;
  assign p2_wins = int'(p2_inc) >= WIN_SCORE;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p1_q    <= '0;
      p2_q    <= '0;
      win_q   <= WIN_NONE;
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      win_q   <= win_d;
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    win_d   = win_q;
    pcnt_d  = pcnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_rise) begin
          state_d = PLAY;
          p1_d    = '0;
          p2_d    = '0;
        end
      end
      PLAY: begin
        if (go_rise && is_player(phys_winner)) begin
          pulse_d = 1'b1;
          if (phys_winner == WIN_P1) p1_d = p1_inc;
          else                       p2_d = p2_inc;
          if ((phys_winner == WIN_P1) ? p1_wins : p2_wins) begin
            state_d = OVER;
            win_d   = phys_winner;
          end else begin
            state_d = PAUSE;
            pcnt_d  = PAUSE_LOAD;
          end
        end
      end
      PAUSE: begin
        if (frame_tick) begin
          if (pcnt_q == '0) state_d = PLAY;
          else              pcnt_d  = pcnt_q - PCNT_W'(1);
        end
      end
      OVER: begin
        if (st_rise) begin
          state_d = PLAY;
          p1_d    = '0;
          p2_d    = '0;
          win_d   = WIN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign phys_en      = frame_tick & (state_q == PLAY);
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign match_state  = state_q;
  assign match_winner = win_q;
  assign point_pulse  = pulse_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - directed vector bench for match_ctrl
// Expectations follow MATCH_WIN_BY_TWO_EN when it is defined for the build.
module tb_match_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_PLAY = 2'd1, S_PAUSE = 2'd2, S_OVER = 2'd3;

  typedef struct {
    logic       rst_n, tick, start, valid, go;
    logic [1:0] win;
    logic       exp_en;
    logic [1:0] exp_state;
    logic [3:0] exp_p1, exp_p2;
    logic       exp_pulse;
    logic [1:0] exp_win;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, frame_tick, start_btn, phys_valid, phys_game_over;
  logic [1:0] phys_winner;
  logic       phys_en, point_pulse;
  logic [3:0] p1_score, p2_score;
  logic [1:0] match_state, match_winner;

  int errors = 0;
  int checks = 0;
  int vec_no = 0;
  int c1, c2;
  vec_t tbl [9];

  match_ctrl #(.WIN_SCORE(7), .SCORE_W(4), .PAUSE_FRAMES(90)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_tick     (frame_tick),
    .start_btn      (start_btn),
    .phys_valid     (phys_valid),
    .phys_game_over (phys_game_over),
    .phys_winner    (phys_winner),
    .phys_en        (phys_en),
    .p1_score       (p1_score),
    .p2_score       (p2_score),
    .match_state    (match_state),
    .match_winner   (match_winner),
    .point_pulse    (point_pulse)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, t, s, v, g, input logic [1:0] w,
                              input logic een, input logic [1:0] est,
                              input int e1, e2, input logic ep, input logic [1:0] ew);
    vec_t x;
    x.rst_n = r; x.tick = t; x.start = s; x.valid = v; x.go = g; x.win = w;
    x.exp_en = een; x.exp_state = est; x.exp_p1 = 4'(e1); x.exp_p2 = 4'(e2);
    x.exp_pulse = ep; x.exp_win = ew;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vector %0d): got %0d expected %0d", name, vec_no, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n = v.rst_n; frame_tick = v.tick; start_btn = v.start;
    phys_valid = v.valid; phys_game_over = v.go; phys_winner = v.win;
    #1 chk("phys_en", 32'(phys_en), 32'(v.exp_en));
    @(posedge clk);
    #1;
    chk("match_state",  32'(match_state),  32'(v.exp_state));
    chk("p1_score",     32'(p1_score),     32'(v.exp_p1));
    chk("p2_score",     32'(p2_score),     32'(v.exp_p2));
    chk("point_pulse",  32'(point_pulse),  32'(v.exp_pulse));
    chk("match_winner", 32'(match_winner), 32'(v.exp_win));
    vec_no++;
  endtask

  // game_over stays high and physics is frozen while paused
  task automatic run_pause(input int p1, input int p2);
    for (int i = 0; i < 90; i++)
      apply(mk(1, 1, 0, 0, 1, 0, 0, (i == 89) ? S_PLAY : S_PAUSE, p1, p2, 0, 0));
  endtask

  task automatic resume(input int p1, input int p2);
    apply(mk(1, 1, 0, 1, 0, 0, 1, S_PLAY, p1, p2, 0, 0));
  endtask

  task automatic point(input logic [1:0] w, input logic tk, input int e1, input int e2,
                       input logic [1:0] est, input logic [1:0] ew);
    apply(mk(1, tk, 0, 1, 1, w, tk, est, e1, e2, 1, ew));
    if (est == S_PAUSE) begin
      run_pause(e1, e2);
      resume(e1, e2);
    end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
    phys_valid = 1'b0; phys_game_over = 1'b0; phys_winner = 2'd0;

    tbl[0] = mk(0, 0, 0, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 1, 0, 0, 0, S_IDLE,  0, 0, 0, 0);
    tbl[2] = mk(1, 0, 1, 0, 0, 0, 0, S_PLAY,  0, 0, 0, 0);
    tbl[3] = mk(1, 1, 1, 1, 0, 0, 1, S_PLAY,  0, 0, 0, 0);
    tbl[4] = mk(1, 0, 0, 1, 1, 1, 0, S_PAUSE, 1, 0, 1, 0);
    for (int i = 5; i < 9; i++)
      tbl[i] = mk(1, 0, 0, 1, 1, 1, 0, S_PAUSE, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) apply(tbl[i]);

    run_pause(1, 0);
    resume(1, 0);

    // illegal winner code: no point, no pulse
    apply(mk(1, 0, 0, 1, 1, 3, 0, S_PLAY, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 1, 0, 0, 0, S_PLAY, 1, 0, 0, 0));

    c1 = 1; c2 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) begin
        c2++;
        point(2, 1'(k == 3), c1, c2, S_PAUSE, 0);
      end else begin
        c1++;
        point(1, 1'(k == 3), c1, c2, S_PAUSE, 0);
      end
    end
`ifdef MATCH_WIN_BY_TWO_EN
    point(2, 0, 6, 6, S_PAUSE, 0);
    point(1, 0, 7, 6, S_PAUSE, 0);
    point(1, 0, 8, 6, S_OVER, 1);
    c1 = 8; c2 = 6;
`else
    point(1, 0, 7, 5, S_OVER, 1);
    c1 = 7; c2 = 5;
`endif
    apply(mk(1, 1, 0, 0, 1, 0, 0, S_OVER, c1, c2, 0, 1));
    apply(mk(1, 0, 1, 0, 1, 0, 0, S_PLAY, 0, 0, 0, 0));
    resume(0, 0);

`ifdef MATCH_WIN_BY_TWO_EN
    for (int k = 1; k <= 14; k++) begin
      point(1, 0, k, k - 1, S_PAUSE, 0);
      point(2, 0, k, k, S_PAUSE, 0);
    end
    point(1, 0, 15, 14, S_OVER, 1);
    apply(mk(1, 0, 1, 0, 1, 0, 0, S_PLAY, 0, 0, 0, 0));
    resume(0, 0);
`endif

    // reset mid-pause with pause_cnt at 40
    apply(mk(1, 0, 0, 1, 1, 1, 0, S_PAUSE, 1, 0, 1, 0));
    for (int i = 0; i < 49; i++)
      apply(mk(1, 1, 0, 0, 1, 0, 0, S_PAUSE, 1, 0, 0, 0));
    apply(mk(0, 1, 0, 0, 1, 0, 0, S_IDLE, 0, 0, 0, 0));
    apply(mk(1, 1, 0, 0, 0, 0, 0, S_IDLE, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 1, 1, 1, 0, S_IDLE, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
